led_trail_pwm: RTL

Downstream stage of the LED walker. It takes the walker's 8-bit LED pattern and drives the physical LEDs through per-LED PWM. Each LED jumps to full brightness while its pattern bit is set, then fades linearly once the bit clears, leaving a decaying trail behind the walking light. Sits between the walker output and the board LED pins, in the same clock domain as the walker.

---
 rtl/led_trail_pwm_if.sv | 30 +++
 rtl/led_trail_pwm.sv | 96 +++++++++
 2 files changed

// File: rtl/led_trail_pwm_if.sv
// LED trail PWM bus
//
// Purpose: groups the walker pattern input and the PWM drive outputs of
// led_trail_pwm so that the stage can be connected with one port.
//
// Signals:
//   i_led        [7:0]  pattern from the LED walker (driven by the master)
//   o_led        [7:0]  PWM-modulated LED drive (driven by the slave)
//   o_decay_stb         one-cycle pulse per decay tick (driven by the slave)
//
// Modports:
//   master  - the side that supplies the pattern and observes the LEDs
//   slave   - the led_trail_pwm block itself
interface led_trail_pwm_if;
  logic [7:0] i_led;
  logic [7:0] o_led;
  logic       o_decay_stb;

  modport master (
    output i_led,
    input  o_led,
    input  o_decay_stb
  );

  modport slave (
    input  i_led,
    output o_led,
    output o_decay_stb
  );
endinterface

// File: rtl/led_trail_pwm.sv
// led_trail_pwm
//
// Purpose: drives eight LEDs with per-LED PWM so that a walking light leaves
// a fading trail. An LED whose pattern bit is set is held at full brightness;
// once the bit clears its brightness drops by DECAY_STEP on every decay tick,
// saturating at zero.
//
// Parameters:
//   DECAY_PERIOD  clock cycles between decay ticks (2 .. 2^32-1)
//   DECAY_STEP    brightness removed per decay tick (1 .. 255)
//
// Ports:
//   i_clk        system clock, rising edge
//   i_reset      asynchronous active-high reset
//   bus.i_led    walker pattern, any bit combination accepted
//   bus.o_led    registered PWM drive, duty = brightness/256
//   bus.o_decay_stb registered one-cycle pulse per decay tick
module led_trail_pwm #(
  parameter logic [31:0] DECAY_PERIOD = 32'd100000,
  parameter logic [7:0]  DECAY_STEP   = 8'd16
) (
  input  logic            i_clk,
  input  logic            i_reset,
  led_trail_pwm_if.slave  bus
);

  logic [31:0] dcnt_reg;
  logic [7:0]  pcnt_reg;
  logic        stb_reg;
  logic        tick;
  logic [7:0]  led_bits;

  // Decay tick is the last count of the decay timer; it is used
  // combinationally by the brightness registers on the same edge that
  // wraps the timer.
  assign tick = (dcnt_reg == (DECAY_PERIOD - 32'd1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      dcnt_reg <= 32'd0;
      stb_reg  <= 1'b0;
    end else if (tick) begin
      dcnt_reg <= 32'd0;
      stb_reg  <= 1'b1;
    end else begin
      dcnt_reg <= dcnt_reg + 32'd1;
      stb_reg  <= 1'b0;
    end
  end

  // Free-running PWM phase; deliberately not aligned to the decay timer.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pcnt_reg <= 8'd0;
    end else begin
      pcnt_reg <= pcnt_reg + 8'd1;
    end
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_led
      logic [7:0] br_reg;
      logic [7:0] br_next;
      logic       lit_reg;

      // Pattern bit overrides decay, so an LED that is still lit on a tick
      // edge stays at full brightness.
      always_comb begin
        br_next = br_reg;
        if (bus.i_led[gi]) begin
          br_next = 8'hFF;
        end else if (tick) begin
          br_next = (br_reg > DECAY_STEP) ? (br_reg - DECAY_STEP) : 8'h00;
        end
      end

      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          br_reg  <= 8'h00;
          lit_reg <= 1'b0;
        end else begin
          br_reg  <= br_next;
          // Compare uses the pre-edge brightness and PWM phase, so a new
          // brightness shows on the LED one edge after it is loaded.
          lit_reg <= (br_reg > pcnt_reg);
        end
      end

      assign led_bits[gi] = lit_reg;
    end
  endgenerate

  assign bus.o_led       = led_bits;
  assign bus.o_decay_stb = stb_reg;

endmodule
